dmem_arbiter: RTL and testbench

Single-port data-memory arbiter and sequencer sharing the 32-bit data RAM between three requesters: the UART programmer (word writes), the CPU execute stage (32-bit and 128-bit vector loads/stores) and the on-board debug/IO reader. The UART programmer has absolute priority; CPU and debug share the port round-robin. 128-bit accesses are split into four sequential 32-bit beats. Sits between the execute/register stage, the UART loader, the IO interface and the data RAM.

---
 rtl/dmem_arb_pkg.sv | 12 +
 rtl/dmem_arb_pick.sv | 24 ++
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 tb/tb_dmem_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state codes, requester ids and beat constants for the data-memory arbiter
package dmem_arb_pkg;
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_ISSUE = 2'd1;
    localparam state_t S_DRAIN = 2'd2;
    localparam state_t S_RESP  = 2'd3;
    typedef enum logic [1:0] {REQ_UPG, REQ_CPU, REQ_DBG} req_id_e;
    localparam int WIDE_BEATS = 4;
    localparam int BEAT_W = $clog2(WIDE_BEATS);
    localparam logic [BEAT_W-1:0] LAST_WIDE = BEAT_W'(WIDE_BEATS - 1);
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: UART programmer wins outright; CPU and debug alternate, last granted loses a tie
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic    clk_i,
    input  logic    reset_n_i,
    input  logic    en_i,
    input  logic    upg_req_i,
    input  logic    cpu_req_i,
    input  logic    dbg_req_i,
    output logic    vld_o,
    output req_id_e win_o
);
    logic cpu_pri_q;
    assign vld_o = en_i && (upg_req_i || cpu_req_i || dbg_req_i);
    assign win_o = upg_req_i ? REQ_UPG : (cpu_req_i && (!dbg_req_i || cpu_pri_q)) ? REQ_CPU : REQ_DBG;
    // Hand priority to the other side after every cpu or debug grant
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            cpu_pri_q <= 1'b1;
        else if (vld_o && win_o != REQ_UPG)
            cpu_pri_q <= win_o == REQ_DBG;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one 32-bit data RAM between UART loader, CPU (32/128-bit) and debug reader
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              upg_req_i,
    input  logic [ADDR_W-1:0] upg_adr_i,
    input  logic [31:0]       upg_dat_i,
    output logic              upg_gnt_o,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic              cpu_wide_i,
    input  logic [31:0]       cpu_adr_i,
    input  logic [127:0]      cpu_dat_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [127:0]      cpu_rdata_o,
    output logic              cpu_err_o,
    input  logic              dbg_req_i,
    input  logic [ADDR_W-1:0] dbg_adr_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [31:0]       dbg_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic [31:0]       mem_wdat_o,
    input  logic [31:0]       mem_rdat_i,
    output logic              busy_o
);
    state_t            state_q, state_d;
    req_id_e           owner_q, win;
    logic              vld, we_q, wide_q, err_q, idle, issue, last, cpu_bad, cap_en;
    logic [BEAT_W-1:0] beat_q, cap_idx;
    logic [ADDR_W-1:0] adr_q;
    logic [127:0]      dat_q, cpu_rdata_q;
    logic [31:0]       dbg_rdata_q;

    assign idle    = state_q == S_IDLE;
    assign issue   = state_q == S_ISSUE;
    assign last    = beat_q == (wide_q ? LAST_WIDE : '0);
    assign cpu_bad = (cpu_wide_i ? |cpu_adr_i[3:0] : |cpu_adr_i[1:0]) || |cpu_adr_i[31:ADDR_W+2];
    // Read data for beat k arrives while beat k+1 issues, the last one in DRAIN
    assign cap_en  = !we_q && ((issue && beat_q != '0) || state_q == S_DRAIN);
    assign cap_idx = issue ? beat_q - 1'b1 : beat_q;

    dmem_arb_pick u_pick (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (idle && reset_n_i),
        .upg_req_i (upg_req_i),
        .cpu_req_i (cpu_req_i),
        .dbg_req_i (dbg_req_i),
        .vld_o     (vld),
        .win_o     (win)
    );

    // Sequencer: a rejected CPU access skips the RAM and goes straight to the response cycle
    always_comb begin
        state_d = idle  ? (vld ? ((win == REQ_CPU && cpu_bad) ? S_RESP : S_ISSUE) : S_IDLE)
                : issue ? (last ? (we_q ? S_IDLE : S_DRAIN) : S_ISSUE)
                : state_q == S_DRAIN ? S_RESP : S_IDLE;
    end

    // Latch the winner's request at accept and step through the beats
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            owner_q <= REQ_UPG;
            we_q    <= 1'b0;
            wide_q  <= 1'b0;
            err_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            if (vld) begin
                owner_q <= win;
                we_q    <= win == REQ_UPG || (win == REQ_CPU && cpu_we_i);
                wide_q  <= win == REQ_CPU && cpu_wide_i;
                err_q   <= win == REQ_CPU && cpu_bad;
                adr_q   <= win == REQ_UPG ? upg_adr_i : win == REQ_CPU ? cpu_adr_i[ADDR_W+1:2] : dbg_adr_i;
                dat_q   <= win == REQ_UPG ? {96'd0, upg_dat_i} : cpu_dat_i;
                beat_q  <= '0;
            end else if (issue && !last) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    // Per-requester read buffers; a CPU load clears its buffer so narrow upper bits and errors read 0
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else if (vld && win == REQ_CPU && !cpu_we_i) begin
            cpu_rdata_q <= '0;
        end else if (cap_en && owner_q == REQ_CPU) begin
            cpu_rdata_q[32*cap_idx +: 32] <= mem_rdat_i;
        end else if (cap_en && owner_q == REQ_DBG) begin
            dbg_rdata_q <= mem_rdat_i;
        end
    end

    assign upg_gnt_o    = vld && win == REQ_UPG;
    assign cpu_gnt_o    = vld && win == REQ_CPU;
    assign dbg_gnt_o    = vld && win == REQ_DBG;
    assign mem_en_o     = issue;
    assign mem_we_o     = issue && we_q;
    assign mem_adr_o    = issue ? adr_q | ADDR_W'(beat_q) : '0;
    assign mem_wdat_o   = issue ? dat_q[32*beat_q +: 32] : '0;
    assign cpu_rvalid_o = state_q == S_RESP && owner_q == REQ_CPU && !we_q;
    assign cpu_err_o    = state_q == S_RESP && err_q;
    assign dbg_rvalid_o = state_q == S_RESP && owner_q == REQ_DBG;
    assign cpu_rdata_o  = cpu_rdata_q;
    assign dbg_rdata_o  = dbg_rdata_q;
    assign busy_o       = !idle;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random transactions checked against a transaction-level model
module tb_dmem_arbiter;
    logic         clk_i, reset_n_i;
    logic         upg_req_i, upg_gnt_o;
    logic [13:0]  upg_adr_i, dbg_adr_i, mem_adr_o;
    logic [31:0]  upg_dat_i, cpu_adr_i, dbg_rdata_o, mem_wdat_o, mem_rdat_i;
    logic         cpu_req_i, cpu_we_i, cpu_wide_i, cpu_gnt_o, cpu_rvalid_o, cpu_err_o;
    logic [127:0] cpu_dat_i, cpu_rdata_o;
    logic         dbg_req_i, dbg_gnt_o, dbg_rvalid_o, mem_en_o, mem_we_o, busy_o;

    dmem_arbiter #(.ADDR_W(14)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .upg_req_i(upg_req_i), .upg_adr_i(upg_adr_i), .upg_dat_i(upg_dat_i), .upg_gnt_o(upg_gnt_o),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_wide_i(cpu_wide_i), .cpu_adr_i(cpu_adr_i),
        .cpu_dat_i(cpu_dat_i), .cpu_gnt_o(cpu_gnt_o), .cpu_rvalid_o(cpu_rvalid_o),
        .cpu_rdata_o(cpu_rdata_o), .cpu_err_o(cpu_err_o),
        .dbg_req_i(dbg_req_i), .dbg_adr_i(dbg_adr_i), .dbg_gnt_o(dbg_gnt_o),
        .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o), .mem_wdat_o(mem_wdat_o),
        .mem_rdat_i(mem_rdat_i), .busy_o(busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [31:0] seed(int a);
        return a * 32'h9E3779B1 ^ 32'h5A5A5A5A;
    endfunction

    // RAM model: one-cycle read latency, unwritten words hold a seeded pattern
    bit [31:0] ram [16384];
    bit        wr  [16384];
    always @(posedge clk_i) begin
        if (mem_en_o) begin
            if (mem_we_o) begin
                ram[mem_adr_o] <= mem_wdat_o;
                wr[mem_adr_o]  <= 1'b1;
            end
            mem_rdat_i <= wr[mem_adr_o] ? ram[mem_adr_o] : seed(int'(mem_adr_o));
        end
    end

    int           vec, errs, last_rr;
    bit           pend [3];
    bit           r_we [3], r_wide [3];
    logic [31:0]  r_adr [3];
    logic [127:0] r_dat [3];
    logic [31:0]  ref_mem [16384];
    logic [127:0] cpu_hold;
    logic [31:0]  dbg_hold;

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        vec++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        upg_req_i  = pend[0];
        upg_adr_i  = r_adr[0][13:0];
        upg_dat_i  = r_dat[0][31:0];
        cpu_req_i  = pend[1];
        cpu_we_i   = r_we[1];
        cpu_wide_i = r_wide[1];
        cpu_adr_i  = r_adr[1];
        cpu_dat_i  = r_dat[1];
        dbg_req_i  = pend[2];
        dbg_adr_i  = r_adr[2][13:0];
    endtask

    task automatic new_req(int i);
        int r;
        pend[i]  = 1'b1;
        r_dat[i] = {$urandom, $urandom, $urandom, $urandom};
        r_adr[i] = $urandom_range(0, 63);
        if (i == 1) begin
            r_we[1]   = 1'($urandom_range(0, 1));
            r_wide[1] = 1'($urandom_range(0, 1));
            r         = $urandom_range(0, 9);
            r_adr[1]  = $urandom_range(0, 255);
            if (r > 1) r_adr[1] = r_adr[1] - r_adr[1] % (r_wide[1] ? 16 : 4);
            if (r == 1) r_adr[1] = r_adr[1] + (32'h1 << $urandom_range(16, 31));
        end
    endtask

    // One transaction from the IDLE negedge to the IDLE negedge after it completes
    task automatic step();
        int           w, beats, endc, rv;
        bit           we, bad;
        logic [13:0]  wa;
        logic [127:0] exp_rd;
        w = pend[0] ? 0 : (pend[1] && pend[2]) ? (last_rr == 1 ? 2 : 1) : pend[1] ? 1 : 2;
        drive();
        #1;
        chk("upg_gnt", 128'(upg_gnt_o), 128'(w == 0));
        chk("cpu_gnt", 128'(cpu_gnt_o), 128'(w == 1));
        chk("dbg_gnt", 128'(dbg_gnt_o), 128'(w == 2));
        if (w != 0) last_rr = w;
        we    = w == 0 || (w == 1 && r_we[1]);
        beats = (w == 1 && r_wide[1]) ? 4 : 1;
        wa    = w == 1 ? r_adr[1][15:2] : r_adr[w][13:0];
        bad   = w == 1 && (r_adr[1] % (r_wide[1] ? 16 : 4) != 0 || r_adr[1] >= 32'h10000);
        exp_rd = '0;
        if (!bad)
            for (int k = 0; k < beats; k++)
                if (we) ref_mem[wa + k] = r_dat[w][32*k +: 32];
                else exp_rd[32*k +: 32] = ref_mem[wa + k];
        endc = bad ? 2 : we ? beats + 1 : beats + 3;
        rv   = bad ? 1 : beats + 2;
        if (w == 1 && !we) cpu_hold = exp_rd;
        if (w == 2) dbg_hold = exp_rd[31:0];
        pend[w] = 1'b0;
        for (int c = 1; c <= endc; c++) begin
            @(negedge clk_i);
            drive();
            chk("busy", 128'(busy_o), 128'(c != endc));
            if (c != endc) chk("gnt_busy", 128'({upg_gnt_o, cpu_gnt_o, dbg_gnt_o}), 128'(0));
            chk("mem_en", 128'(mem_en_o), 128'(!bad && c <= beats));
            if (!bad && c <= beats) begin
                chk("mem_adr", 128'(mem_adr_o), 128'(wa + c - 1));
                chk("mem_we", 128'(mem_we_o), 128'(we));
                if (we) chk("mem_wdat", 128'(mem_wdat_o), 128'(r_dat[w][32*(c-1) +: 32]));
            end
            chk("cpu_err", 128'(cpu_err_o), 128'(w == 1 && bad && c == 1));
            chk("cpu_rvalid", 128'(cpu_rvalid_o), 128'(w == 1 && !we && c == rv));
            chk("dbg_rvalid", 128'(dbg_rvalid_o), 128'(w == 2 && c == rv));
            if (w == 1 && !we && c == rv) chk("cpu_rdata", cpu_rdata_o, exp_rd);
            if (w == 2 && c == rv) chk("dbg_rdata", 128'(dbg_rdata_o), exp_rd);
        end
        chk("cpu_hold", cpu_rdata_o, cpu_hold);
        chk("dbg_hold", 128'(dbg_rdata_o), 128'(dbg_hold));
    endtask

    initial begin
        vec = 0; errs = 0; last_rr = 2;
        cpu_hold = '0; dbg_hold = '0;
        for (int a = 0; a < 16384; a++) ref_mem[a] = seed(a);
        for (int i = 0; i < 3; i++) begin
            pend[i] = 1'b0; r_we[i] = 1'b0; r_wide[i] = 1'b0; r_adr[i] = '0; r_dat[i] = '0;
        end
        reset_n_i = 1'b0;
        drive();
        repeat (3) @(negedge clk_i);
        chk("rst_strobes", 128'({upg_gnt_o, cpu_gnt_o, dbg_gnt_o, cpu_rvalid_o, cpu_err_o, dbg_rvalid_o}), 128'(0));
        chk("rst_mem", 128'({mem_en_o, mem_we_o, mem_adr_o, mem_wdat_o}), 128'(0));
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_rdata", {cpu_rdata_o ^ 128'(dbg_rdata_o)}, 128'(0));
        reset_n_i = 1'b1;

        // UART loads 0xDEADBEEF into word 4, CPU reads it back at byte 0x10
        pend[0] = 1'b1; r_adr[0] = 4; r_dat[0] = 128'hDEADBEEF;
        step();
        pend[1] = 1'b1; r_we[1] = 1'b0; r_wide[1] = 1'b0; r_adr[1] = 32'h10;
        step();
        chk("deadbeef", cpu_rdata_o, 128'hDEADBEEF);

        // Wide store then wide load at 0x40
        pend[1] = 1'b1; r_we[1] = 1'b1; r_wide[1] = 1'b1; r_adr[1] = 32'h40;
        r_dat[1] = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
        step();
        pend[1] = 1'b1; r_we[1] = 1'b0;
        step();
        chk("wide_back", cpu_rdata_o, 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0);

        // Three-way contention, then cpu/debug alternation
        pend[0] = 1'b1; pend[1] = 1'b1; pend[2] = 1'b1;
        r_adr[0] = 8; r_dat[0] = 128'h0BADF00D; r_wide[1] = 1'b0; r_adr[1] = 32'h20; r_adr[2] = 8;
        repeat (3) step();
        repeat (2) begin
            pend[1] = 1'b1; pend[2] = 1'b1;
            step();
            step();
        end

        // Misaligned and out-of-range CPU accesses
        pend[1] = 1'b1; r_we[1] = 1'b0; r_wide[1] = 1'b0; r_adr[1] = 32'h6;
        step();
        pend[1] = 1'b1; r_adr[1] = 32'h0001_0000;
        step();
        pend[1] = 1'b1; r_we[1] = 1'b1; r_wide[1] = 1'b1; r_adr[1] = 32'h48;
        step();

        // Reset asserted while beat 2 of a wide load is on the RAM port
        pend[1] = 1'b1; r_we[1] = 1'b0; r_wide[1] = 1'b1; r_adr[1] = 32'h80;
        drive();
        #1;
        chk("abort_gnt", 128'(cpu_gnt_o), 128'(1));
        pend[1] = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            drive();
        end
        chk("abort_beat2", 128'(mem_adr_o), 128'(14'h22));
        reset_n_i = 1'b0;
        #1;
        chk("abort_mem", 128'({mem_en_o, mem_adr_o, busy_o}), 128'(0));
        chk("abort_rdata", cpu_rdata_o, 128'(0));
        repeat (3) begin
            @(negedge clk_i);
            chk("abort_strobe", 128'({cpu_rvalid_o, cpu_err_o}), 128'(0));
        end
        reset_n_i = 1'b1; last_rr = 2; cpu_hold = '0; dbg_hold = '0;
        pend[1] = 1'b1; r_wide[1] = 1'b0; r_adr[1] = 32'h10;
        step();

        // Random mix of requesters, kept pending until granted
        for (int n = 0; n < 80; n++) begin
            for (int i = 0; i < 3; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
            if (!(pend[0] || pend[1] || pend[2])) new_req(1);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
